tx_dcoffset_iq: RTL and testbench
=================================

# tx_dcoffset_iq

Transmit-side DC offset compensation for an I/Q sample stream: adds a programmable I and Q offset to each sample ahead of the DAC so that analog LO leakage is cancelled. Offsets are written over the settings bus into a staging pair and committed atomically. Committed changes either take effect immediately or are slewed toward the new target a bounded step per sample, so that retuning during a burst does not splatter. It sits in the TX DSP chain just before the DAC interface, as the mirror of the RX DC correction stage.

## Interface
- WIDTH, 16: sample and offset width, two's complement.
- ADDR, 8'd0: base settings address. The block uses ADDR and ADDR+1.
- SLEW_SHIFT, 4: maximum offset change per accepted sample, STEP = 2^SLEW_SHIFT LSBs.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- set_stb  in  1  settings write strobe.
- set_addr  in  8  settings address.
- set_data  in  32  settings payload.
- in_stb  in  1  input sample valid, single-cycle qualifier.
- in_i, in_q  in  WIDTH each  input sample.
- out_stb  out  1  output sample valid.
- out_i, out_q  out  WIDTH each  compensated, saturated sample.
- slewing  out  1  high while the applied offset differs from the committed target.

## Operation
- Register ADDR:
  - [WIDTH-1:0] goes to the staged I offset.
  - bit 31 goes to the staged enable.
  - Writing ADDR has no effect on the output.
- Register ADDR+1:
  - [WIDTH-1:0] goes to the staged Q offset.
  - On the same cycle, commit: target_i ← staged I, target_q ← set_data[WIDTH-1:0], enable ← staged enable.
  - bit 30 = jump: cur_i/cur_q ← new target on that cycle, no slew.
- Applied offset:
  - When enable is 1, the applied offset is (cur_i, cur_q).
  - When enable is 0, the applied offset is 0. cur still tracks the target.
- Slew FSM, two states:
  - IDLE: cur == target on both channels.
  - SLEW: entered on a non-jump commit with cur ≠ target.
  - In SLEW, each in_stb updates cur_x += clamp(target_x − cur_x, −STEP, +STEP), per channel independently.
  - The difference is computed at WIDTH+1 bits, so there is no wrap.
  - The FSM returns to IDLE on the cycle both channels equal their targets.
  - No in_stb means no progress.
- slewing is registered and equals (state == SLEW).
- A commit during SLEW retargets immediately and continues from the current cur. A jump commit during SLEW goes to IDLE.
- Datapath:
  - Stage 1: sum_x = sext(in_x) + sext(offset_x) at WIDTH+1 bits.
  - Stage 2: saturate to [−2^(WIDTH−1), 2^(WIDTH−1)−1]. out_x is registered.
- Each sample uses the cur value present on its in_stb cycle, i.e. the value before that strobe's slew update.
- Settings writes to other addresses are ignored.

## Timing
- Latency: out_stb is in_stb delayed exactly 2 cycles. out_i/out_q are valid with out_stb and hold between strobes.
- Back-to-back in_stb every cycle is supported at full rate.
- Commit and in_stb in the same cycle:
  - That sample uses the old cur and the old enable.
  - Slew (or the jump value) applies from the next strobe.
- ADDR and ADDR+1 writes are one per cycle. Only one address matches per cycle.
- Reset:
  - out_i, out_q, out_stb, slewing = 0.
  - staged, target and cur offsets = 0; enable = 0; FSM = IDLE.
  - The pipeline valids are cleared, so samples in flight are dropped.
- Reset mid-slew: the next cycle shows slewing=0 and offsets 0. No output strobe appears for samples in flight.

## Test plan
- Reset: assert rst with in_stb active → out_stb, out_i, out_q and slewing stay 0. After release, in_i=500, in_q=−7 → out 500, −7 exactly 2 cycles later.
- Atomic staging:
  - Write ADDR = 0x8000_0064 (enable, I=100). Samples (1000, 1000) → out (1000, 1000).
  - Then write ADDR+1 = 0x4000_FFCE (jump, Q=−50). Next samples → (1100, 950).
- Saturation:
  - Jump offset I = 32767, sample 100 → 32767.
  - Jump offset Q = −32768, sample −1 → −32768.
  - Offset 0, samples pass unchanged.
- Slew (SLEW_SHIFT=4, STEP=16):
  - From 0, commit I=40, Q=−20 with no jump; stream (0, 0) every cycle.
  - Required outputs: I = 0, 16, 32, 40, 40 and Q = 0, −16, −20, −20.
  - slewing is high from commit until the cycle after the third strobe.
  - Gaps in in_stb stall progress.
- Simultaneous events:
  - Commit on the same cycle as in_stb → that sample uses the old offset.
  - Retarget mid-slew to I = −40 → I reverses by 16 per strobe from its current value.
- Disable and reset mid-slew:
  - Commit with enable=0 while targets are nonzero → outputs equal inputs, while slewing still progresses.
  - rst mid-slew → slewing=0, and after release the outputs carry zero offset.

Source files
------------

// File: rtl/tx_dcoffset_iq_if.sv
// Bundles the settings write port, the sample input and the sample output of tx_dcoffset_iq.
// Latency: none. This file only groups signals; the 2-cycle pipeline lives in the design.
// Backpressure: none. in_stb and out_stb are single-cycle qualifiers with no ready path.
//
// Signals:
//   set_stb/set_addr/set_data : settings bus write (one write per cycle)
//   in_stb/in_i/in_q          : input I/Q sample and its valid strobe
//   out_stb/out_i/out_q       : compensated, saturated I/Q sample and its strobe
//   slewing                   : applied offset is still moving toward the committed target
// Modports: master drives settings and samples; slave is the compensation block.
interface tx_dcoffset_iq_if #(
    parameter int WIDTH = 16
);
    logic                    set_stb;
    logic [7:0]              set_addr;
    logic [31:0]             set_data;

    logic                    in_stb;
    logic signed [WIDTH-1:0] in_i;
    logic signed [WIDTH-1:0] in_q;

    logic                    out_stb;
    logic signed [WIDTH-1:0] out_i;
    logic signed [WIDTH-1:0] out_q;
    logic                    slewing;

    modport master (
        output set_stb, set_addr, set_data,
        output in_stb, in_i, in_q,
        input  out_stb, out_i, out_q, slewing
    );

    modport slave (
        input  set_stb, set_addr, set_data,
        input  in_stb, in_i, in_q,
        output out_stb, out_i, out_q, slewing
    );
endinterface

// File: rtl/tx_dcoffset_iq.sv
// TX DC offset compensation: adds a programmable, optionally slewed I/Q offset ahead of the DAC.
// Latency: out_stb follows in_stb by exactly 2 cycles (sum stage, saturate stage); full rate.
// Backpressure: none; every in_stb produces an out_stb, reset drops samples in flight.
//
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   bus      : tx_dcoffset_iq_if.slave (settings write, input sample, output sample, slewing)
// Settings map:
//   ADDR   : [WIDTH-1:0] staged I offset, [31] staged enable (no visible effect on its own)
//   ADDR+1 : [WIDTH-1:0] Q offset, written together with the staged I/enable as one commit;
//            [30] jump, which loads the applied offset straight to the new target
module tx_dcoffset_iq #(
    parameter int         WIDTH      = 16,
    parameter logic [7:0] ADDR       = 8'd0,
    parameter int         SLEW_SHIFT = 4
) (
    input  logic           clk,
    input  logic           rst,
    tx_dcoffset_iq_if.slave bus
);

    localparam logic [7:0]              ADDR_Q = ADDR + 8'd1;
    // Largest offset change per accepted sample, held at WIDTH+1 bits so that
    // it compares directly against the unwrapped difference.
    localparam logic signed [WIDTH:0]   STEP   = (WIDTH+1)'(2 ** SLEW_SHIFT);
    localparam logic signed [WIDTH-1:0] MAXV   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MINV   = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SLEW = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Settings state
    // ------------------------------------------------------------------
    // The staged Q value is not held separately: it only ever matters at the
    // moment of commit, and it arrives on the same write that commits.
    logic signed [WIDTH-1:0] staged_i;
    logic                    staged_en;
    logic signed [WIDTH-1:0] target_i;
    logic signed [WIDTH-1:0] target_q;
    logic signed [WIDTH-1:0] cur_i;
    logic signed [WIDTH-1:0] cur_q;
    logic                    enable;
    state_t                  state;

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic                    vld1;
    logic signed [WIDTH:0]   sum_i;
    logic signed [WIDTH:0]   sum_q;
    logic                    out_stb_r;
    logic signed [WIDTH-1:0] out_i_r;
    logic signed [WIDTH-1:0] out_q_r;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic                    wr_i;
    logic                    wr_q;
    logic                    wr_jump;
    logic signed [WIDTH-1:0] wr_q_val;

    assign wr_i     = bus.set_stb && (bus.set_addr == ADDR);
    assign wr_q     = bus.set_stb && (bus.set_addr == ADDR_Q);
    assign wr_jump  = bus.set_data[30];
    assign wr_q_val = bus.set_data[WIDTH-1:0];

    // Only a subset of the 32-bit payload is decoded; fold the rest so the
    // whole bus is visibly consumed.
    logic unused_set_bits;
    assign unused_set_bits = ^bus.set_data;

    // ------------------------------------------------------------------
    // Slew step: move cur toward tgt by at most STEP. The difference is
    // formed one bit wider than the operands so opposite-sign extremes
    // cannot wrap; the clamped step always lands between cur and tgt, so
    // the WIDTH-bit result is exact.
    // ------------------------------------------------------------------
    function automatic logic signed [WIDTH-1:0] slew_next(
        input logic signed [WIDTH-1:0] cur,
        input logic signed [WIDTH-1:0] tgt
    );
        logic signed [WIDTH:0] diff;
        logic signed [WIDTH:0] d;
        diff = {tgt[WIDTH-1], tgt} - {cur[WIDTH-1], cur};
        if (diff > STEP) begin
            d = STEP;
        end else if (diff < -STEP) begin
            d = -STEP;
        end else begin
            d = diff;
        end
        return cur + d[WIDTH-1:0];
    endfunction

    function automatic logic signed [WIDTH-1:0] saturate(
        input logic signed [WIDTH:0] s
    );
        // The two top bits disagree only when the sum left the WIDTH-bit range;
        // the top bit then tells which rail to clip to.
        if (s[WIDTH] != s[WIDTH-1]) begin
            return s[WIDTH] ? MINV : MAXV;
        end
        return s[WIDTH-1:0];
    endfunction

    logic signed [WIDTH-1:0] nxt_i;
    logic signed [WIDTH-1:0] nxt_q;
    logic signed [WIDTH-1:0] off_i;
    logic signed [WIDTH-1:0] off_q;
    logic signed [WIDTH:0]   ext_in_i;
    logic signed [WIDTH:0]   ext_in_q;
    logic signed [WIDTH:0]   ext_off_i;
    logic signed [WIDTH:0]   ext_off_q;

    always_comb begin
        nxt_i = slew_next(cur_i, target_i);
        nxt_q = slew_next(cur_q, target_q);
    end

    // cur keeps tracking the target while disabled so that re-enabling
    // picks up wherever the slew has got to.
    assign off_i     = enable ? cur_i : '0;
    assign off_q     = enable ? cur_q : '0;
    assign ext_in_i  = {bus.in_i[WIDTH-1], bus.in_i};
    assign ext_in_q  = {bus.in_q[WIDTH-1], bus.in_q};
    assign ext_off_i = {off_i[WIDTH-1], off_i};
    assign ext_off_q = {off_q[WIDTH-1], off_q};

    // ------------------------------------------------------------------
    // Settings, target tracking and slew FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            staged_i  <= '0;
            staged_en <= 1'b0;
            target_i  <= '0;
            target_q  <= '0;
            cur_i     <= '0;
            cur_q     <= '0;
            enable    <= 1'b0;
            state     <= S_IDLE;
        end else begin
            if (wr_i) begin
                staged_i  <= bus.set_data[WIDTH-1:0];
                staged_en <= bus.set_data[31];
            end

            // A commit takes priority over a slew step in the same cycle: a
            // strobe arriving with the commit sees the old offset and leaves
            // cur alone, so motion toward the new target starts on the next strobe.
            if (wr_q) begin
                target_i <= staged_i;
                target_q <= wr_q_val;
                enable   <= staged_en;
                if (wr_jump) begin
                    cur_i <= staged_i;
                    cur_q <= wr_q_val;
                    state <= S_IDLE;
                end else if ((cur_i != staged_i) || (cur_q != wr_q_val)) begin
                    state <= S_SLEW;
                end else begin
                    state <= S_IDLE;
                end
            end else if ((state == S_SLEW) && bus.in_stb) begin
                cur_i <= nxt_i;
                cur_q <= nxt_q;
                if ((nxt_i == target_i) && (nxt_q == target_q)) begin
                    state <= S_IDLE;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath: stage 1 widened sum, stage 2 saturate
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            vld1      <= 1'b0;
            sum_i     <= '0;
            sum_q     <= '0;
            out_stb_r <= 1'b0;
            out_i_r   <= '0;
            out_q_r   <= '0;
        end else begin
            vld1 <= bus.in_stb;
            if (bus.in_stb) begin
                sum_i <= ext_in_i + ext_off_i;
                sum_q <= ext_in_q + ext_off_q;
            end
            // Outputs only update on a valid sample and hold between strobes.
            out_stb_r <= vld1;
            if (vld1) begin
                out_i_r <= saturate(sum_i);
                out_q_r <= saturate(sum_q);
            end
        end
    end

    assign bus.out_stb = out_stb_r;
    assign bus.out_i   = out_i_r;
    assign bus.out_q   = out_q_r;
    // state is a flop, so this is a registered flag.
    assign bus.slewing = (state == S_SLEW);

endmodule

// File: tb/tb_tx_dcoffset_iq.sv
// Directed bench for tx_dcoffset_iq: table of jump-committed offsets plus hand sequences.
// Latency: checks out_stb exactly 2 cycles after in_stb.
// Backpressure: none exercised; the block has no ready path.
module tb_tx_dcoffset_iq;

    localparam int         WIDTH = 16;
    localparam logic [7:0] ADDR  = 8'h20;
    localparam logic [7:0] ADDRQ = ADDR + 8'd1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tx_dcoffset_iq_if #(.WIDTH(WIDTH)) bus ();

    tx_dcoffset_iq #(
        .WIDTH(WIDTH),
        .ADDR(ADDR),
        .SLEW_SHIFT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        bit en;
        int oi;
        int oq;
        int ii;
        int iq;
        int ei;
        int eq;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [7:0] addr, input logic [31:0] data);
        bus.set_stb  = 1'b1;
        bus.set_addr = addr;
        bus.set_data = data;
        cyc();
        bus.set_stb  = 1'b0;
    endtask

    task automatic commit(input bit en, input int oi, input int oq, input bit jump);
        write(ADDR,  {en, 15'd0, 16'(oi)});
        write(ADDRQ, {1'b0, jump, 14'd0, 16'(oq)});
    endtask

    task automatic sample(input int i, input int q);
        bus.in_stb = 1'b1;
        bus.in_i   = 16'(i);
        bus.in_q   = 16'(q);
        cyc();
        bus.in_stb = 1'b0;
    endtask

    // One sample, then check the output it produces two edges after its strobe.
    task automatic send_chk(input string name, input int i, input int q,
                            input int ei, input int eq);
        sample(i, q);
        cyc();
        check({name, " out_stb"}, int'(bus.out_stb), 1);
        check({name, " out_i"}, int'(bus.out_i), ei);
        check({name, " out_q"}, int'(bus.out_q), eq);
    endtask

    int got_i[$];
    int got_q[$];
    int exp_si[5] = '{0, 16, 32, 40, 40};
    int exp_sq[5] = '{0, -16, -20, -20, -20};

    initial begin
        // en, off_i, off_q, in_i, in_q, exp_i, exp_q
        vecs[0] = '{1'b1,  32767,      0,    100,      0,  32767,      0};
        vecs[1] = '{1'b1,      0, -32768,      0,     -1,      0, -32768};
        vecs[2] = '{1'b1,      0,      0,   1234,  -4321,   1234,  -4321};
        vecs[3] = '{1'b1, -32768,  32767,     -1,      1, -32768,  32767};
        vecs[4] = '{1'b1,   -100,    200, -32700,  32600, -32768,  32767};
        vecs[5] = '{1'b0,    500,    500,      7,     -7,      7,     -7};
        vecs[6] = '{1'b1,    500,   -500,      7,     -7,    507,   -507};
        vecs[7] = '{1'b1,  32767, -32768,  32767, -32768,  32767, -32768};

        bus.set_stb  = 1'b0;
        bus.set_addr = 8'd0;
        bus.set_data = 32'd0;
        bus.in_stb   = 1'b1;
        bus.in_i     = 16'sd123;
        bus.in_q     = -16'sd45;

        // Reset held with samples streaming: nothing may come out.
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("rst out_stb", int'(bus.out_stb), 0);
            check("rst out_i", int'(bus.out_i), 0);
            check("rst out_q", int'(bus.out_q), 0);
            check("rst slewing", int'(bus.slewing), 0);
        end
        rst        = 1'b0;
        bus.in_stb = 1'b0;
        cyc();

        // Latency: exactly two cycles, single pulse, value holds afterwards.
        sample(500, -7);
        check("lat early out_stb", int'(bus.out_stb), 0);
        cyc();
        check("lat out_stb", int'(bus.out_stb), 1);
        check("lat out_i", int'(bus.out_i), 500);
        check("lat out_q", int'(bus.out_q), -7);
        cyc();
        check("lat pulse end", int'(bus.out_stb), 0);
        check("lat hold out_i", int'(bus.out_i), 500);

        // Staging alone is invisible; the ADDR+1 write commits both channels.
        write(ADDR, 32'h8000_0064);
        send_chk("staged only", 1000, 1000, 1000, 1000);
        write(ADDRQ, 32'h4000_FFCE);
        check("jump slewing", int'(bus.slewing), 0);
        send_chk("committed", 1000, 1000, 1100, 950);

        // Neighbouring addresses are ignored.
        write(8'(ADDR + 8'd2), 32'h4000_7FFF);
        write(8'(ADDR - 8'd1), 32'hC000_7FFF);
        send_chk("other addr", 1000, 1000, 1100, 950);

        // Offset/saturation table, each applied with a jump commit.
        for (int v = 0; v < 8; v++) begin
            commit(vecs[v].en, vecs[v].oi, vecs[v].oq, 1'b1);
            send_chk($sformatf("vec%0d", v), vecs[v].ii, vecs[v].iq, vecs[v].ei, vecs[v].eq);
        end

        // Slew from 0 to (40, -20), streaming zeros every cycle.
        commit(1'b1, 0, 0, 1'b1);
        write(ADDR,  {1'b1, 15'd0, 16'd40});
        write(ADDRQ, {1'b0, 1'b0, 14'd0, 16'hFFEC});
        check("slew start", int'(bus.slewing), 1);
        bus.in_stb = 1'b1;
        bus.in_i   = '0;
        bus.in_q   = '0;
        for (int c = 0; c < 7; c++) begin
            if (c == 5) bus.in_stb = 1'b0;
            cyc();
            if (c == 1) check("slew mid", int'(bus.slewing), 1);
            if (c == 2) check("slew done", int'(bus.slewing), 0);
            if (bus.out_stb) begin
                got_i.push_back(int'(bus.out_i));
                got_q.push_back(int'(bus.out_q));
            end
        end
        check("slew count", got_i.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < got_i.size()) begin
                check($sformatf("slew i%0d", k), got_i[k], exp_si[k]);
                check($sformatf("slew q%0d", k), got_q[k], exp_sq[k]);
            end
        end

        // Commit on the same cycle as a strobe: that sample uses the old offset.
        write(ADDR, {1'b1, 15'd0, 16'd200});
        bus.set_stb  = 1'b1;
        bus.set_addr = ADDRQ;
        bus.set_data = {1'b0, 1'b0, 14'd0, 16'hFFEC};
        bus.in_stb   = 1'b1;
        bus.in_i     = '0;
        bus.in_q     = '0;
        cyc();
        bus.set_stb  = 1'b0;
        bus.in_stb   = 1'b0;
        check("simul slewing", int'(bus.slewing), 1);
        cyc();
        check("simul out_stb", int'(bus.out_stb), 1);
        check("simul old out_i", int'(bus.out_i), 40);
        check("simul old out_q", int'(bus.out_q), -20);
        send_chk("simul next", 0, 0, 40, -20);

        // Gaps without strobes make no progress.
        cyc();
        cyc();
        cyc();
        check("gap slewing", int'(bus.slewing), 1);
        send_chk("gap stall", 0, 0, 56, -20);

        // Retarget to -40 mid-slew: reverses 16 per strobe from 72.
        write(ADDR,  {1'b1, 15'd0, 16'hFFD8});
        write(ADDRQ, {1'b0, 1'b0, 14'd0, 16'hFFEC});
        send_chk("retarget 0", 0, 0, 72, -20);
        send_chk("retarget 1", 0, 0, 56, -20);
        send_chk("retarget 2", 0, 0, 40, -20);

        // Disable while slewing: outputs pass through, cur keeps moving (24 -> 8 -> -8).
        write(ADDR,  {1'b0, 15'd0, 16'hFFD8});
        write(ADDRQ, {1'b0, 1'b0, 14'd0, 16'hFFEC});
        send_chk("disabled 0", 1000, -1000, 1000, -1000);
        send_chk("disabled 1", 1000, -1000, 1000, -1000);
        check("disabled slewing", int'(bus.slewing), 1);

        // Reset mid-slew with a sample in flight.
        bus.in_stb = 1'b1;
        bus.in_i   = 16'sd5;
        bus.in_q   = 16'sd5;
        cyc();
        bus.in_stb = 1'b0;
        rst        = 1'b1;
        cyc();
        check("rst mid out_stb", int'(bus.out_stb), 0);
        check("rst mid slewing", int'(bus.slewing), 0);
        cyc();
        check("rst mid out_stb 2", int'(bus.out_stb), 0);
        check("rst mid out_i", int'(bus.out_i), 0);
        rst = 1'b0;
        // Non-jump enable commit to zero: a stale cur would show up as slewing or an offset.
        commit(1'b1, 0, 0, 1'b0);
        check("post rst slewing", int'(bus.slewing), 0);
        send_chk("post rst", 300, -300, 300, -300);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
